// File: rtl/eth_stats_snapshot_fifo.sv
// eth_stats_snapshot_fifo
//   Captures {current_time, counters_in} snapshots when the counters change or on a
//   programmable period, buffers them in a FIFO_DEPTH-entry FIFO, and exposes
//   configuration, status, drop count and the popped head snapshot through a simple
//   word register port (driven by an AXI4-Lite slave adapter).
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   reg_rd_*              read port: level req, combinational ack/data/ok
//   reg_wr_*              write port: level req, ack same cycle (POP of data: next cycle)
//   enable, srst          CFG.enable and CFG.srst
//   current_time          free-running timestamp captured with each snapshot
//   counters_in           counter i at [i*CNT_WIDTH +: CNT_WIDTH]
// Register map (word address = byte address >> 2)
//   0 CFG [0]enable [1]srst [2]periodic [3]drop_newest
//   1 STATUS [15:0]occupancy [16]overflow (W1C)
//   2 POP (write-only, reads 0)   3 PERIOD   4 DROPPED (saturating, any write clears)
//   8.. head snapshot: time lo/hi, then each counter low word first
module eth_stats_snapshot_fifo #(
  parameter int unsigned NUM_COUNTERS = 6,
  parameter int unsigned CNT_WIDTH    = 64,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 12
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              reg_rd_req,
  input  logic [ADDR_WIDTH-1:0]             reg_rd_addr,
  output logic [31:0]                       reg_rd_data,
  output logic                              reg_rd_ack,
  output logic                              reg_rd_ok,
  input  logic                              reg_wr_req,
  input  logic [ADDR_WIDTH-1:0]             reg_wr_addr,
  input  logic [31:0]                       reg_wr_data,
  input  logic [3:0]                        reg_wr_strb,
  output logic                              reg_wr_ack,
  output logic                              reg_wr_ok,
  output logic                              enable,
  output logic                              srst,
  input  logic [63:0]                       current_time,
  input  logic [NUM_COUNTERS*CNT_WIDTH-1:0] counters_in
);

  localparam int unsigned CntBits   = NUM_COUNTERS * CNT_WIDTH;
  localparam int unsigned SnapBits  = 64 + CntBits;
  localparam int unsigned SnapWords = SnapBits / 32;
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW      = PtrW + 1;
  localparam int unsigned WordW     = ADDR_WIDTH - 2;

  localparam logic [WordW-1:0] WCfg     = WordW'(0);
  localparam logic [WordW-1:0] WStatus  = WordW'(1);
  localparam logic [WordW-1:0] WPop     = WordW'(2);
  localparam logic [WordW-1:0] WPeriod  = WordW'(3);
  localparam logic [WordW-1:0] WDropped = WordW'(4);
  localparam logic [WordW-1:0] WSnapLo  = WordW'(8);
  localparam logic [WordW-1:0] WSnapEnd = WordW'(8 + SnapWords);

  // Configuration and port-handshake state (cleared only by rst_n)
  logic [3:0]  cfg_q, cfg_d;
  logic        pop_ack_q, pop_ack_d;
  logic        busy_q, busy_d;

  // Collector state (cleared by rst_n or srst)
  logic [31:0]         period_q, period_d;
  logic [31:0]         period_cnt_q, period_cnt_d;
  logic [31:0]         dropped_q, dropped_d;
  logic                overflow_q, overflow_d;
  logic [CntBits-1:0]  shadow_q, shadow_d;
  logic [SnapBits-1:0] snap_q, snap_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0]     count_q, count_d;
  logic [SnapBits-1:0] mem_q [FIFO_DEPTH];

  logic [WordW-1:0] rd_word, wr_word;
  logic [31:0]      wmask;
  logic             cfg_wr, status_wr, period_wr, dropped_wr, snap_wr_hit, wr_mapped;
  logic             is_pop, pop_start, pop_do;
  logic             periodic, drop_newest, period_hit, change_hit, trigger;
  logic             fifo_full, fifo_empty, push, drop, drop_old, rd_adv;
  logic [31:0]      status_word;
  logic             unused_addr_bits;

  assign rd_word = reg_rd_addr[ADDR_WIDTH-1:2];
  assign wr_word = reg_wr_addr[ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^{reg_rd_addr[1:0], reg_wr_addr[1:0]};

  assign wmask = {{8{reg_wr_strb[3]}}, {8{reg_wr_strb[2]}},
                  {8{reg_wr_strb[1]}}, {8{reg_wr_strb[0]}}};

  assign enable      = cfg_q[0];
  assign srst        = cfg_q[1];
  assign periodic    = cfg_q[2];
  assign drop_newest = cfg_q[3];

  // Write decode; non-POP writes act in the cycle the request is seen
  assign cfg_wr      = reg_wr_req && (wr_word == WCfg);
  assign status_wr   = reg_wr_req && (wr_word == WStatus);
  assign period_wr   = reg_wr_req && (wr_word == WPeriod);
  assign dropped_wr  = reg_wr_req && (wr_word == WDropped) && (reg_wr_strb != 4'b0000);
  assign snap_wr_hit = (wr_word >= WSnapLo) && (wr_word < WSnapEnd);
  assign wr_mapped   = (wr_word == WCfg) || (wr_word == WStatus) || (wr_word == WPeriod) ||
                       (wr_word == WDropped) || snap_wr_hit;

  // POP: only the first cycle of a request acts; busy blocks repeats until req drops
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == OccW'(FIFO_DEPTH));
  assign is_pop     = reg_wr_req && (wr_word == WPop);
  assign pop_start  = is_pop && !busy_q;
  assign pop_do     = pop_start && (reg_wr_strb != 4'b0000) && !fifo_empty;

  assign reg_wr_ack = (reg_wr_req && !is_pop) || (pop_start && !pop_do) || pop_ack_q;
  assign reg_wr_ok  = pop_ack_q || is_pop || wr_mapped;

  // Sample trigger
  assign period_hit = (period_q != '0) && (period_cnt_q >= (period_q - 32'd1));
  assign change_hit = (counters_in != shadow_q);
  assign trigger    = enable && (periodic ? period_hit : change_hit);

  // Full-FIFO handling: a same-cycle pop makes room, otherwise drop newest or oldest
  assign drop     = trigger && fifo_full && !pop_do;
  assign drop_old = drop && !drop_newest;
  assign push     = trigger && (!fifo_full || pop_do || !drop_newest);
  assign rd_adv   = pop_do || drop_old;

  assign status_word = {15'b0, overflow_q, 16'(count_q)};

  always_comb begin
    cfg_d = cfg_q;
    if (cfg_wr) begin
      cfg_d = (cfg_q & ~wmask[3:0]) | (reg_wr_data[3:0] & wmask[3:0]);
    end else if (cfg_q[1]) begin
      cfg_d = 4'b0010;
    end
  end

  always_comb begin
    pop_ack_d = pop_do;
    busy_d    = reg_wr_req && (busy_q || pop_start);
  end

  always_comb begin
    period_d = period_q;
    if (period_wr) begin
      period_d = (period_q & ~wmask) | (reg_wr_data & wmask);
    end

    period_cnt_d = 32'd0;
    if (enable && periodic && (period_q != '0) && !period_hit) begin
      period_cnt_d = period_cnt_q + 32'd1;
    end

    dropped_d = dropped_q;
    if (dropped_wr) begin
      dropped_d = 32'd0;
    end else if (drop && (dropped_q != 32'hFFFF_FFFF)) begin
      dropped_d = dropped_q + 32'd1;
    end

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (status_wr && reg_wr_strb[2] && reg_wr_data[16]) begin
      overflow_d = 1'b0;
    end

    shadow_d = trigger ? counters_in : shadow_q;
    snap_d   = pop_do ? mem_q[rd_ptr_q] : snap_q;
    rd_ptr_d = rd_ptr_q + PtrW'(rd_adv);
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    count_d  = count_q + OccW'(push) - OccW'(rd_adv);
  end

  // Read mux
  always_comb begin
    reg_rd_data = 32'd0;
    reg_rd_ok   = 1'b0;
    if (rd_word == WCfg) begin
      reg_rd_data = {28'd0, cfg_q};
      reg_rd_ok   = 1'b1;
    end else if (rd_word == WStatus) begin
      reg_rd_data = status_word;
      reg_rd_ok   = 1'b1;
    end else if (rd_word == WPop) begin
      reg_rd_ok   = 1'b1;
    end else if (rd_word == WPeriod) begin
      reg_rd_data = period_q;
      reg_rd_ok   = 1'b1;
    end else if (rd_word == WDropped) begin
      reg_rd_data = dropped_q;
      reg_rd_ok   = 1'b1;
    end else begin
      for (int unsigned k = 0; k < SnapWords; k++) begin
        if (rd_word == WordW'(8 + k)) begin
          reg_rd_data = snap_q[k*32 +: 32];
          reg_rd_ok   = 1'b1;
        end
      end
    end
  end

  assign reg_rd_ack = reg_rd_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q     <= '0;
      pop_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      pop_ack_q <= pop_ack_d;
      busy_q    <= busy_d;
    end
  end

  // A soft reset clears the collector but leaves a pending POP ack to complete
  always_ff @(posedge clk) begin
    if (!rst_n || cfg_q[1]) begin
      period_q     <= '0;
      period_cnt_q <= '0;
      dropped_q    <= '0;
      overflow_q   <= 1'b0;
      shadow_q     <= '0;
      snap_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      period_q     <= period_d;
      period_cnt_q <= period_cnt_d;
      dropped_q    <= dropped_d;
      overflow_q   <= overflow_d;
      shadow_q     <= shadow_d;
      snap_q       <= snap_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {counters_in, current_time};
    end
  end

endmodule

// File: tb/tb_eth_stats_snapshot_fifo.sv
module tb_eth_stats_snapshot_fifo;

  localparam int unsigned NumCnt = 6;
  localparam int unsigned CntW   = 64;

  logic               clk;
  logic               rst_n;
  logic               reg_rd_req;
  logic [11:0]        reg_rd_addr;
  logic [31:0]        reg_rd_data;
  logic               reg_rd_ack;
  logic               reg_rd_ok;
  logic               reg_wr_req;
  logic [11:0]        reg_wr_addr;
  logic [31:0]        reg_wr_data;
  logic [3:0]         reg_wr_strb;
  logic               reg_wr_ack;
  logic               reg_wr_ok;
  logic               enable;
  logic               srst;
  logic [63:0]        current_time;
  logic [NumCnt*CntW-1:0] counters_in;

  eth_stats_snapshot_fifo #(
    .NUM_COUNTERS(NumCnt),
    .CNT_WIDTH   (CntW),
    .FIFO_DEPTH  (16),
    .ADDR_WIDTH  (12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_rd_req  (reg_rd_req),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data),
    .reg_rd_ack  (reg_rd_ack),
    .reg_rd_ok   (reg_rd_ok),
    .reg_wr_req  (reg_wr_req),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_strb (reg_wr_strb),
    .reg_wr_ack  (reg_wr_ack),
    .reg_wr_ok   (reg_wr_ok),
    .enable      (enable),
    .srst        (srst),
    .current_time(current_time),
    .counters_in (counters_in)
  );

  typedef struct {
    logic [31:0] data;
    bit          ok;
    bit          ports;
    string       name;
  } rd_exp_t;

  typedef struct {
    bit    ok;
    int    lat;
    string name;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int      n_vec;
  int      n_err;
  int      cyc;
  bit      done;

  localparam logic [11:0] ACfg  = 12'h000;
  localparam logic [11:0] AStat = 12'h004;
  localparam logic [11:0] APop  = 12'h008;
  localparam logic [11:0] APer  = 12'h00C;
  localparam logic [11:0] ADrop = 12'h010;
  localparam logic [11:0] ATLo  = 12'h020;
  localparam logic [11:0] ATHi  = 12'h024;
  localparam logic [11:0] AC0Lo = 12'h028;
  localparam logic [11:0] AC0Hi = 12'h02C;
  localparam logic [11:0] ALast = 12'h054;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Free-running timestamp, advanced away from the sampling edge
  initial begin
    current_time = 64'd0;
    forever begin
      @(negedge clk);
      current_time = current_time + 64'd1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want summary before limit");
    $fatal(1, "watchdog");
  end

  task automatic rd(input logic [11:0] addr, input logic [31:0] data, input bit ok,
                    input bit ports, input string name);
    rd_exp_t e;
    e.data = data; e.ok = ok; e.ports = ports; e.name = name;
    rd_q.push_back(e);
    @(posedge clk); #1;
    reg_rd_req  = 1'b1;
    reg_rd_addr = addr;
    @(posedge clk); #1;
    reg_rd_req  = 1'b0;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input bit ok, input int lat, input int hold, input bit chg,
                    input logic [63:0] chg_val, input string name);
    wr_exp_t e;
    e.ok = ok; e.lat = lat; e.name = name;
    wr_q.push_back(e);
    @(posedge clk); #1;
    reg_wr_req  = 1'b1;
    reg_wr_addr = addr;
    reg_wr_data = data;
    reg_wr_strb = strb;
    if (chg) counters_in[63:0] = chg_val;
    repeat (hold) @(posedge clk);
    #1;
    reg_wr_req = 1'b0;
  endtask

  task automatic wreg(input logic [11:0] addr, input logic [31:0] data, input string name);
    wr(addr, data, 4'hF, 1'b1, 0, 1, 1'b0, 64'd0, name);
  endtask

  task automatic pop(input string name);
    wr(APop, 32'd0, 4'hF, 1'b1, 1, 2, 1'b0, 64'd0, name);
  endtask

  task automatic step_cnt(input logic [63:0] val);
    @(posedge clk); #1;
    counters_in[63:0] = val;
  endtask

  // Monitor / scoreboard: every ack is matched against the next expectation
  initial begin
    rd_exp_t re;
    wr_exp_t we;
    bit      wr_prev;
    int      wr_start;
    int      lat;
    n_vec = 0; n_err = 0; wr_prev = 1'b0; wr_start = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        n_vec++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
          n_err++;
          $display("FAIL pending_acks: got %0d rd + %0d wr unanswered, want 0 + 0",
                   rd_q.size(), wr_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
      if (reg_rd_req && reg_rd_ack) begin
        n_vec++;
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_unexpected: got ack data=%08h, want no ack", reg_rd_data);
        end else begin
          re = rd_q.pop_front();
          if (reg_rd_data !== re.data || reg_rd_ok !== re.ok ||
              (re.ports && (enable !== re.data[0] || srst !== re.data[1]))) begin
            n_err++;
            $display("FAIL %s: got data=%08h ok=%0b en=%0b srst=%0b, want data=%08h ok=%0b",
                     re.name, reg_rd_data, reg_rd_ok, enable, srst, re.data, re.ok);
          end
        end
      end
      if (reg_wr_req && !wr_prev) wr_start = cyc;
      wr_prev = reg_wr_req;
      if (reg_wr_ack) begin
        n_vec++;
        lat = cyc - wr_start;
        if (wr_q.size() == 0) begin
          n_err++;
          $display("FAIL wr_unexpected: got ack ok=%0b lat=%0d, want no ack", reg_wr_ok, lat);
        end else begin
          we = wr_q.pop_front();
          if (reg_wr_ok !== we.ok || lat != we.lat) begin
            n_err++;
            $display("FAIL %s: got ok=%0b latency=%0d, want ok=%0b latency=%0d",
                     we.name, reg_wr_ok, lat, we.ok, we.lat);
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] v;
    done = 1'b0;
    rst_n = 1'b0;
    reg_rd_req = 1'b0; reg_rd_addr = '0;
    reg_wr_req = 1'b0; reg_wr_addr = '0; reg_wr_data = '0; reg_wr_strb = '0;
    counters_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    rd(ACfg,  32'd0, 1'b1, 1'b1, "reset_cfg");
    rd(AStat, 32'd0, 1'b1, 1'b0, "reset_status");
    rd(APer,  32'd0, 1'b1, 1'b0, "reset_period");
    rd(ADrop, 32'd0, 1'b1, 1'b0, "reset_dropped");
    rd(ATLo,  32'd0, 1'b1, 1'b0, "reset_snap_time");

    // Change mode: counter0 0->5 captured with time 100
    wreg(ACfg, 32'd1, "wr_cfg_enable");
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (current_time == 64'd99) break;
    end
    counters_in[63:0] = 64'd5;
    rd(AStat, 32'd1, 1'b1, 1'b0, "change_occ1");
    pop("pop_first");
    rd(ATLo,  32'd100, 1'b1, 1'b0, "snap_time_lo");
    rd(ATHi,  32'd0,   1'b1, 1'b0, "snap_time_hi");
    rd(AC0Lo, 32'd5,   1'b1, 1'b0, "snap_cnt0_lo");
    rd(AC0Hi, 32'd0,   1'b1, 1'b0, "snap_cnt0_hi");
    rd(AStat, 32'd0,   1'b1, 1'b0, "after_pop_occ0");

    // Periodic, PERIOD=10, exactly 100 enabled cycles
    wreg(APer, 32'd10, "wr_period");
    wreg(ACfg, 32'd5, "wr_cfg_periodic");
    v = current_time;
    repeat (98) @(posedge clk);
    wreg(ACfg, 32'd4, "wr_cfg_disable");
    rd(AStat, 32'd10, 1'b1, 1'b0, "periodic_occ10");
    for (int i = 1; i <= 10; i++) begin
      pop("pop_periodic");
      rd(ATLo, 32'(v + 64'(10 * i)), 1'b1, 1'b0, "periodic_time");
    end

    // Full FIFO, drop newest
    wreg(ACfg, 32'd9, "wr_cfg_drop_newest");
    for (int i = 0; i < 20; i++) step_cnt(64'(100 + i));
    rd(AStat, 32'h0001_0010, 1'b1, 1'b0, "dropnew_status");
    rd(ADrop, 32'd4, 1'b1, 1'b0, "dropnew_dropped");
    pop("pop_dropnew");
    rd(AC0Lo, 32'd100, 1'b1, 1'b0, "dropnew_head");
    rd(AStat, 32'h0001_000F, 1'b1, 1'b0, "dropnew_occ15");
    wr(AStat, 32'h0001_0000, 4'b0100, 1'b1, 0, 1, 1'b0, 64'd0, "wr_status_w1c");
    rd(AStat, 32'h0000_000F, 1'b1, 1'b0, "overflow_cleared");
    wreg(ADrop, 32'd0, "wr_dropped_clear");
    rd(ADrop, 32'd0, 1'b1, 1'b0, "dropped_cleared");
    wr(APer, 32'hAABB_CCDD, 4'b0101, 1'b1, 0, 1, 1'b0, 64'd0, "wr_period_strb");
    rd(APer, 32'h00BB_00DD, 1'b1, 1'b0, "period_strobed");

    // Full FIFO, drop oldest (fresh start through soft reset)
    wreg(ACfg, 32'd2, "wr_cfg_srst");
    step_cnt(64'd0);
    wreg(ACfg, 32'd1, "wr_cfg_enable2");
    for (int i = 0; i < 20; i++) step_cnt(64'(200 + i));
    rd(AStat, 32'h0001_0010, 1'b1, 1'b0, "dropold_status");
    rd(ADrop, 32'd4, 1'b1, 1'b0, "dropold_dropped");
    pop("pop_dropold");
    rd(AC0Lo, 32'd204, 1'b1, 1'b0, "dropold_head");

    // POP held five cycles removes one entry
    wr(APop, 32'd0, 4'hF, 1'b1, 1, 5, 1'b0, 64'd0, "pop_held5");
    rd(AC0Lo, 32'd205, 1'b1, 1'b0, "held_head");
    rd(AStat, 32'h0001_000E, 1'b1, 1'b0, "held_occ14");

    // Pop and trigger in the same cycle on a full FIFO
    step_cnt(64'd300);
    step_cnt(64'd301);
    wr(APop, 32'd0, 4'hF, 1'b1, 1, 2, 1'b1, 64'd302, "pop_with_trigger");
    rd(AStat, 32'h0001_0010, 1'b1, 1'b0, "poptrig_occ16");
    rd(ADrop, 32'd4, 1'b1, 1'b0, "poptrig_dropped");
    rd(AC0Lo, 32'd206, 1'b1, 1'b0, "poptrig_head");

    // Soft reset
    wreg(ACfg, 32'd2, "wr_cfg_srst2");
    rd(AStat, 32'd0, 1'b1, 1'b0, "srst_occ0");
    rd(ACfg,  32'd2, 1'b1, 1'b1, "srst_cfg");
    rd(ADrop, 32'd0, 1'b1, 1'b0, "srst_dropped");
    rd(AC0Lo, 32'd0, 1'b1, 1'b0, "srst_snap");
    wreg(ACfg, 32'd0, "wr_cfg_clear");
    rd(ACfg,  32'd0, 1'b1, 1'b1, "cfg_cleared");

    // POP on empty: same-cycle ack, snapshot untouched
    wr(APop, 32'd0, 4'hF, 1'b1, 0, 1, 1'b0, 64'd0, "pop_empty");
    rd(ATLo, 32'd0, 1'b1, 1'b0, "pop_empty_snap");

    // PERIOD=0 never triggers
    wreg(ACfg, 32'd5, "wr_cfg_period0");
    repeat (30) @(posedge clk);
    wreg(ACfg, 32'd0, "wr_cfg_off");
    rd(AStat, 32'd0, 1'b1, 1'b0, "period0_occ0");

    // Address decode boundaries
    rd(12'hFFC, 32'd0, 1'b0, 1'b0, "rd_ffc_err");
    rd(12'h058, 32'd0, 1'b0, 1'b0, "rd_past_last_err");
    rd(ALast,   32'd0, 1'b1, 1'b0, "rd_last_word");
    rd(12'h014, 32'd0, 1'b0, 1'b0, "rd_unmapped_err");
    rd(APop,    32'd0, 1'b1, 1'b0, "rd_pop_zero");
    wr(12'h018, 32'd0, 4'hF, 1'b0, 0, 1, 1'b0, 64'd0, "wr_unmapped_err");

    repeat (4) @(posedge clk);
    done = 1'b1;
  end

endmodule
